xor_rr_scheduler: RTL and testbench
===================================

Name: xor_rr_scheduler

Overview:
- Shares one WIDTH-bit XOR datapath among four requesters using round-robin arbitration.
- Each requester presents operand pairs with a req/gnt handshake.
- The block computes a^b for the granted requester and returns a registered result tagged with the requester id and parity.
- The result uses a valid/ready handshake toward a single downstream consumer. The block sits between the client logic and the consumer.

Parameters:
- WIDTH, 8, operand/result width in bits (legal range 1..32).
- CNT_W, 16, width of the completed-operation counter.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  reset, asynchronous and active-low; deasserted synchronously to clk externally.
- req  input  4  req[i]=1: requester i has valid operands on op_a/op_b slice i; held until gnt[i].
- op_a  input  4*WIDTH  operand A; requester i on bits [i*WIDTH +: WIDTH].
- op_b  input  4*WIDTH  operand B; same slicing as op_a.
- gnt  output  4  one-hot, single-cycle pulse; operands of slice i are sampled at the end of that cycle.
- busy  output  1  1 while in HOLD (result pending).
- res_valid  output  1  result available.
- res_ready  input  1  consumer accepts result when res_valid & res_ready.
- res_id  output  2  index of the requester that produced res_data.
- res_data  output  WIDTH  registered op_a_i ^ op_b_i.
- res_parity  output  1  XOR-reduction of res_data, registered with it.
- op_count  output  CNT_W  number of results accepted by the consumer; wraps modulo 2^CNT_W.

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE, gnt=0, busy=0, res_valid=0, res_id=0, res_data=0, res_parity=0, op_count=0, rr pointer last=3, so requester 0 has first priority.
- Two-state FSM: IDLE, HOLD.
- IDLE, req==0: stay in IDLE, gnt=0.
- IDLE, req!=0:
  - gnt is combinational (Mealy) in this cycle. The winner is the first set req bit searching last+1, last+2, last+3, last (mod 4).
  - At the clock edge: res_data<=op_a_w^op_b_w, res_parity<=^(op_a_w^op_b_w), res_id<=w, last<=w, res_valid<=1, state<=HOLD.
- Latency: result valid one cycle after the gnt pulse. Throughput is at most one operation per 2 cycles.
- HOLD:
  - gnt=0 regardless of req.
  - res_data, res_id and res_parity stay stable while res_valid=1 and res_ready=0 (backpressure may last indefinitely).
  - On res_valid & res_ready: res_valid<=0, op_count<=op_count+1 (wraps), state<=IDLE.
  - The next grant can occur in the cycle immediately after acceptance.
- res_ready is ignored when res_valid=0. req is ignored outside IDLE. Requesters not granted keep waiting; no request is dropped.
- A requester that deasserts req before gnt is simply not considered. gnt never pulses for a requester whose req=0 in that cycle.
- The rr pointer updates only on a grant, never on acceptance or idle cycles.
- Fairness: with all four req held high, grants are issued in strict order 0,1,2,3,0,…; no requester waits more than 3 other grants.
- busy == (state==HOLD) == res_valid.
- Reset mid-operation (any state): all state returns to reset values immediately; the pending result is discarded and op_count is not incremented.
- Arithmetic: res_data is a pure bitwise XOR of WIDTH bits, with no carries. op_count wraps from 2^CNT_W-1 to 0.

Test Plan:
- Reset, then req=0 for 10 cycles -> gnt=0, res_valid=0, busy=0, op_count=0 throughout.
- req=4'b0010, slice1 op_a=8'hA5, op_b=8'h0F, res_ready=1 -> gnt=4'b0010 for 1 cycle; next cycle res_valid=1, res_id=1, res_data=8'hAA, res_parity=0; op_count=1 after acceptance.
- req=4'b1111 held, res_ready=1, distinct operands per slice -> gnt sequence 0001,0010,0100,1000,0001 at 2-cycle spacing; each res_id/res_data matches its slice.
- After a grant to requester 2, req=4'b1001 -> next gnt=4'b1000 (id 3), then 4'b0001.
- Backpressure: result 8'h3C pending, res_ready=0 for 5 cycles while req=4'b0001 -> res_data stays 8'h3C, gnt=0 and op_count unchanged; res_ready=1 -> accepted, grant to 0 on the following cycle.
- Reset mid-HOLD: assert rst_n=0 between clock edges while res_valid=1 -> res_valid, busy and op_count drop to 0 without waiting for clk. With CNT_W forced to 4 and 16 accepted results -> op_count wraps to 0.

Source files
------------

// File: rtl/xor_rr_scheduler.sv
// -----------------------------------------------------------------------------
// xor_rr_scheduler
//
// Four requesters share one WIDTH-bit XOR datapath. A round-robin arbiter
// picks one pending request, its operands are XORed and the registered
// result is offered to a single downstream consumer with a valid/ready
// handshake. While a result is pending, no new grant is issued.
//
// Ports
//   clk        : system clock, rising edge
//   rst_n      : asynchronous active-low reset
//   req[3:0]   : request per requester, held until its grant
//   op_a/op_b  : operands, requester i on bits [i*WIDTH +: WIDTH]
//   gnt[3:0]   : one-hot single-cycle grant (combinational from req)
//   busy       : a result is pending (HOLD state)
//   res_valid  : result available to the consumer
//   res_ready  : consumer accepts when res_valid & res_ready
//   res_id     : requester index that produced res_data
//   res_data   : registered op_a_i ^ op_b_i
//   res_parity : XOR-reduction of res_data
//   op_count   : results accepted by the consumer, wraps modulo 2^CNT_W
// -----------------------------------------------------------------------------
module xor_rr_scheduler #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [3:0]           req,
    input  logic [4*WIDTH-1:0]   op_a,
    input  logic [4*WIDTH-1:0]   op_b,
    output logic [3:0]           gnt,
    output logic                 busy,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [1:0]           res_id,
    output logic [WIDTH-1:0]     res_data,
    output logic                 res_parity,
    output logic [CNT_W-1:0]     op_count
);

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t           state;
    state_t           state_nxt;

    logic [1:0]       last;       // most recently granted requester
    logic [1:0]       win;        // arbitration winner this cycle
    logic             win_found;
    logic [1:0]       cand;
    logic             grant;
    logic             accept;
    logic [WIDTH-1:0] win_a;
    logic [WIDTH-1:0] win_b;
    logic [WIDTH-1:0] xor_res;

    function automatic logic parity_of(input logic [WIDTH-1:0] d);
        return ^d;
    endfunction

    // Round-robin search: last+1, last+2, last+3, then last itself, so the
    // previous winner only wins again when nobody else is asking.
    always_comb begin
        win       = last;
        win_found = 1'b0;
        cand      = last;
        for (int k = 1; k <= 4; k++) begin
            cand = last + 2'(k);
            if (!win_found && req[cand]) begin
                win       = cand;
                win_found = 1'b1;
            end
        end
    end

    assign grant   = (state == IDLE) && win_found;
    assign accept  = (state == HOLD) && res_ready;

    assign win_a   = op_a[win*WIDTH +: WIDTH];
    assign win_b   = op_b[win*WIDTH +: WIDTH];
    assign xor_res = win_a ^ win_b;

    // Next-state and Mealy grant output.
    always_comb begin
        state_nxt = state;
        gnt       = 4'b0000;
        case (state)
            IDLE: begin
                if (grant) begin
                    gnt       = 4'b0001 << win;
                    state_nxt = HOLD;
                end
            end
            HOLD: begin
                if (accept) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Result capture and round-robin pointer; both move only on a grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last       <= 2'd3;
            res_id     <= 2'd0;
            res_data   <= '0;
            res_parity <= 1'b0;
        end else if (grant) begin
            last       <= win;
            res_id     <= win;
            res_data   <= xor_res;
            res_parity <= parity_of(xor_res);
        end
    end

    // Accepted-result counter; a result discarded by reset is never counted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_count <= '0;
        end else if (accept) begin
            op_count <= op_count + CNT_W'(1);
        end
    end

    assign busy      = (state == HOLD);
    assign res_valid = (state == HOLD);

endmodule

// File: tb/tb_xor_rr_scheduler.sv
module tb_xor_rr_scheduler;

    localparam int W = 8;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [3:0]     req;
    logic [4*W-1:0] op_a;
    logic [4*W-1:0] op_b;
    logic           res_ready;

    logic [3:0]     gnt;
    logic           busy;
    logic           res_valid;
    logic [1:0]     res_id;
    logic [W-1:0]   res_data;
    logic           res_parity;
    logic [15:0]    op_count;

    logic [3:0]     w_gnt;
    logic           w_busy;
    logic           w_res_valid;
    logic [1:0]     w_res_id;
    logic [W-1:0]   w_res_data;
    logic           w_res_parity;
    logic [3:0]     w_op_count;

    always #5 clk = ~clk;

    xor_rr_scheduler #(.WIDTH(W), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .op_a(op_a), .op_b(op_b),
        .gnt(gnt), .busy(busy), .res_valid(res_valid), .res_ready(res_ready),
        .res_id(res_id), .res_data(res_data), .res_parity(res_parity),
        .op_count(op_count)
    );

    // Narrow-counter copy sharing the same stimulus, used for the wrap check.
    xor_rr_scheduler #(.WIDTH(W), .CNT_W(4)) dut_w (
        .clk(clk), .rst_n(rst_n), .req(req), .op_a(op_a), .op_b(op_b),
        .gnt(w_gnt), .busy(w_busy), .res_valid(w_res_valid), .res_ready(res_ready),
        .res_id(w_res_id), .res_data(w_res_data), .res_parity(w_res_parity),
        .op_count(w_op_count)
    );

    int checks = 0;
    int errors = 0;

    // Reference model state
    int           m_hold;
    int           m_last;
    int           m_id;
    logic [W-1:0] m_data;
    int           m_count;
    int           last_grant;
    logic [3:0]   glog[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int pick(input int lst, input logic [3:0] r);
        for (int k = 1; k <= 4; k++) begin
            if (r[(lst + k) % 4]) return (lst + k) % 4;
        end
        return -1;
    endfunction

    // Called at posedge+1 with inputs set; checks at the falling edge, then
    // advances the model across the next rising edge.
    task automatic cycle();
        int         w;
        logic [3:0] eg;
        last_grant = -1;
        @(negedge clk);
        w  = (m_hold == 0) ? pick(m_last, req) : -1;
        eg = (w >= 0) ? 4'(1 << w) : 4'b0000;
        chk("gnt", 32'(gnt), 32'(eg));
        chk("gnt_w", 32'(w_gnt), 32'(eg));
        chk("busy", 32'(busy), 32'(m_hold));
        chk("res_valid", 32'(res_valid), 32'(m_hold));
        chk("op_count", 32'(op_count), 32'(m_count % 65536));
        chk("op_count_w", 32'(w_op_count), 32'(m_count % 16));
        if (m_hold != 0) begin
            chk("res_id", 32'(res_id), 32'(m_id));
            chk("res_data", 32'(res_data), 32'(m_data));
            chk("res_parity", 32'(res_parity), 32'($countones(m_data) % 2));
        end
        if (gnt != 4'b0000) glog.push_back(gnt);
        if (w >= 0) begin
            m_hold     = 1;
            m_id       = w;
            m_data     = op_a[w*W +: W] ^ op_b[w*W +: W];
            m_last     = w;
            last_grant = w;
        end else if (m_hold != 0 && res_ready) begin
            m_hold = 0;
            m_count++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_hold  = 0;
        m_last  = 3;
        m_count = 0;
        m_id    = 0;
        m_data  = '0;
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        req       = 4'b0000;
        res_ready = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        chk("rst_gnt", 32'(gnt), 32'h0);
        chk("rst_valid", 32'(res_valid), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_id", 32'(res_id), 32'h0);
        chk("rst_data", 32'(res_data), 32'h0);
        chk("rst_parity", 32'(res_parity), 32'h0);
        chk("rst_count", 32'(op_count), 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        logic [3:0] pend;
        rst_n     = 1'b0;
        req       = 4'b0000;
        op_a      = '0;
        op_b      = '0;
        res_ready = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        do_reset();

        // Idle with no requests
        repeat (10) cycle();

        // Single request on slice 1
        op_a[1*W +: W] = 8'hA5;
        op_b[1*W +: W] = 8'h0F;
        req       = 4'b0010;
        res_ready = 1'b1;
        glog.delete();
        cycle();
        req = 4'b0000;
        chk("t2_gnt", 32'(glog.size() == 1 ? glog[0] : 4'hF), 32'h2);
        chk("t2_valid", 32'(res_valid), 32'h1);
        chk("t2_id", 32'(res_id), 32'h1);
        chk("t2_data", 32'(res_data), 32'hAA);
        chk("t2_parity", 32'(res_parity), 32'h0);
        cycle();
        chk("t2_count", 32'(op_count), 32'h1);

        // All four requesting: strict rotation from requester 0
        do_reset();
        for (int i = 0; i < 4; i++) begin
            op_a[i*W +: W] = 8'(8'h11 * (i + 1));
            op_b[i*W +: W] = 8'(8'hC3 ^ (i * 8'h24));
        end
        req       = 4'b1111;
        res_ready = 1'b1;
        glog.delete();
        repeat (10) cycle();
        chk("rot_n", 32'(glog.size()), 32'd5);
        if (glog.size() == 5) begin
            chk("rot0", 32'(glog[0]), 32'h1);
            chk("rot1", 32'(glog[1]), 32'h2);
            chk("rot2", 32'(glog[2]), 32'h4);
            chk("rot3", 32'(glog[3]), 32'h8);
            chk("rot4", 32'(glog[4]), 32'h1);
        end
        req = 4'b0000;
        cycle();

        // After requester 2, 1001 goes to 3 then 0
        req = 4'b0100;
        cycle();
        req = 4'b1001;
        glog.delete();
        repeat (4) cycle();
        chk("rr_n", 32'(glog.size()), 32'd2);
        if (glog.size() == 2) begin
            chk("rr0", 32'(glog[0]), 32'h8);
            chk("rr1", 32'(glog[1]), 32'h1);
        end
        req = 4'b0000;
        cycle();

        // Backpressure
        do_reset();
        op_a[0 +: W] = 8'h3C;
        op_b[0 +: W] = 8'h00;
        req       = 4'b0001;
        res_ready = 1'b0;
        cycle();
        for (int i = 0; i < 5; i++) begin
            chk("bp_data", 32'(res_data), 32'h3C);
            chk("bp_gnt", 32'(gnt), 32'h0);
            chk("bp_count", 32'(op_count), 32'h0);
            cycle();
        end
        res_ready = 1'b1;
        cycle();
        chk("bp_acc_count", 32'(op_count), 32'h1);
        glog.delete();
        cycle();
        chk("bp_regrant", 32'(glog.size() == 1 ? glog[0] : 4'hF), 32'h1);

        // Asynchronous reset while a result is pending
        res_ready = 1'b0;
        req       = 4'b0000;
        chk("mid_pre_valid", 32'(res_valid), 32'h1);
        chk("mid_pre_count", 32'(op_count), 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_valid", 32'(res_valid), 32'h0);
        chk("mid_busy", 32'(busy), 32'h0);
        chk("mid_count", 32'(op_count), 32'h0);
        chk("mid_count_w", 32'(w_op_count), 32'h0);
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Sixteen accepted results wrap the 4-bit counter
        res_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            int b;
            b = $urandom_range(0, 3);
            op_a[b*W +: W] = 8'($urandom);
            op_b[b*W +: W] = 8'($urandom);
            req = 4'(1 << b);
            cycle();
            req = 4'b0000;
            cycle();
        end
        chk("wrap_w", 32'(w_op_count), 32'h0);
        chk("wrap_16", 32'(op_count), 32'd16);

        // Randomized traffic against the model
        pend = 4'b0000;
        for (int c = 0; c < 2000; c++) begin
            for (int i = 0; i < 4; i++) begin
                if (!pend[i]) begin
                    if ($urandom_range(0, 2) == 0) begin
                        pend[i] = 1'b1;
                        op_a[i*W +: W] = 8'($urandom);
                        op_b[i*W +: W] = 8'($urandom);
                    end
                end else if ($urandom_range(0, 15) == 0) begin
                    pend[i] = 1'b0;
                end
            end
            res_ready = ($urandom_range(0, 3) != 0);
            req = pend;
            cycle();
            if (last_grant >= 0) pend[last_grant] = 1'b0;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
